// File: rtl/dma_restart_sequencer.sv
// Restart sequencer for the ADC/DAC DMA datapath.
// A restart halts the DMA, waits (bounded) for it to drain, pulses the local
// active-low reset, lets the datapath settle, then reports completion.
// Requests arriving mid-sequence collapse into one pending restart.
module dma_restart_sequencer #(
    parameter int RESET_LEN     = 8,
    parameter int SETTLE_LEN    = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart_req,
    input  logic        dma_idle,
    output logic        halt,
    output logic        local_aresetn,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [15:0] restart_count
);

    // One shared phase counter, wide enough for the longest phase.
    localparam int MAX_LEN_RS = (RESET_LEN > SETTLE_LEN) ? RESET_LEN : SETTLE_LEN;
    localparam int MAX_LEN    = (MAX_LEN_RS > DRAIN_TIMEOUT) ? MAX_LEN_RS : DRAIN_TIMEOUT;
    localparam int CNT_W      = $clog2(MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_LEN - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRAIN  = 3'd1;
    localparam logic [2:0] S_RESET  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             timeout_err_q, timeout_err_d;
    logic [15:0]      restart_count_q, restart_count_d;
    logic             halt_q, local_aresetn_q, busy_q, done_q;

    // Next-state, phase counter, pending-request and status-flag logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d         = state_q;
        cnt_d           = cnt_q;
        pending_d       = pending_q;
        timeout_err_d   = timeout_err_q;
        restart_count_d = restart_count_q;

        case (state_q)
            S_IDLE: begin
                if (restart_req) begin
                    state_d       = S_DRAIN;
                    cnt_d         = '0;
                    timeout_err_d = 1'b0;
                end
            end
            S_DRAIN: begin
                pending_d = pending_q | restart_req;
                if (dma_idle) begin
                    // A drain that completes on the timeout cycle is not a timeout.
                    state_d = S_RESET;
                    cnt_d   = '0;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d       = S_RESET;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESET: begin
                pending_d = pending_q | restart_req;
                if (cnt_q == RESET_LAST) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                pending_d = pending_q | restart_req;
                if (cnt_q == SETTLE_LAST) begin
                    state_d         = S_DONE;
                    cnt_d           = '0;
                    restart_count_d = restart_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // A request in the DONE cycle joins the pending flag and is
                // consumed at this same exit edge.
                if (pending_q || restart_req) begin
                    state_d       = S_DRAIN;
                    cnt_d         = '0;
                    pending_d     = 1'b0;
                    timeout_err_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; outputs are registered from the next state so they
    // change on the same edge as the state they describe.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            pending_q       <= 1'b0;
            timeout_err_q   <= 1'b0;
            restart_count_q <= 16'd0;
            halt_q          <= 1'b0;
            local_aresetn_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pending_q       <= pending_d;
            timeout_err_q   <= timeout_err_d;
            restart_count_q <= restart_count_d;
            halt_q          <= (state_d == S_DRAIN) || (state_d == S_RESET) ||
                               (state_d == S_SETTLE);
            local_aresetn_q <= (state_d != S_RESET);
            busy_q          <= (state_d != S_IDLE);
            done_q          <= (state_d == S_DONE);
        end
    end

    assign halt          = halt_q;
    assign local_aresetn = local_aresetn_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout_err   = timeout_err_q;
    assign restart_count = restart_count_q;

endmodule
